vme_cycle_ctrl: RTL and testbench

VME slave data-transfer cycle controller for the EA4163 board. It synchronises the VME strobes, sequences the address latch, the decoder check, the data-buffer direction and the register read/write strobes, and drives DTACK* and BERR* through their open-collector transceiver enables. It sits between the VME bus pins and the address latch, decoder and register file of the top level, and replaces the ad-hoc strobe gating there.

---
 rtl/vme_pkg.sv | 41 ++++
 rtl/vme_cycle_ctrl_if.sv | 47 ++++
 rtl/vme_sync.sv | 39 +++
 rtl/vme_cycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_vme_cycle_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vme_pkg.sv
// vme_pkg: shared types and constants for the VME slave cycle controller.
//   - vme_state_e : controller state encoding (also exported for debug)
//   - *_DEF       : default synchroniser depth, DTACK delay and ACK watchdog
//   - AM_*        : address-modifier codes used by the board decoder
//   - helpers     : DS* pattern classification on synchronised strobes
package vme_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADDR    = 4'd1,
        ST_DECODE  = 4'd2,
        ST_SKIP    = 4'd3,
        ST_XFER    = 4'd4,
        ST_WAIT    = 4'd5,
        ST_ACK     = 4'd6,
        ST_ERR     = 4'd7,
        ST_RELEASE = 4'd8
    } vme_state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DTACK_DLY_DEF   = 2;
    localparam int ACK_TMO_DEF     = 255;

    // Address-modifier codes decoded by the board (A16/A24/A32 data access).
    localparam logic [5:0] AM_A16_USR      = 6'h29;
    localparam logic [5:0] AM_A16_SUP      = 6'h2D;
    localparam logic [5:0] AM_A24_USR_DATA = 6'h39;
    localparam logic [5:0] AM_A24_SUP_DATA = 6'h3D;
    localparam logic [5:0] AM_A32_USR_DATA = 6'h09;
    localparam logic [5:0] AM_A32_SUP_DATA = 6'h0D;

    // Strobes are active-low: exactly one DS* low marks a byte cycle.
    function automatic logic is_byte_cycle(input logic ds0, input logic ds1);
        return ds0 ^ ds1;
    endfunction

    function automatic logic ds_both_high(input logic ds0, input logic ds1);
        return ds0 & ds1;
    endfunction

endpackage

// File: rtl/vme_cycle_ctrl_if.sv
// vme_cycle_ctrl_if: bus-side and board-side signals of the cycle controller.
//   Inputs  (master -> slave): raw VME strobes AS*/DS0*/DS1*/WRITE* and the
//                               decoder hit for the latched address.
//   Outputs (slave -> master): address latch enable, register strobes, data
//                               buffer enables, DTACK*/BERR* drive controls,
//                               watchdog pulse and the FSM state for debug.
//
// Handshake: this is the VME asynchronous strobe handshake, not valid/ready.
// A cycle is offered by AS* low plus at least one DS* low; the slave answers
// with DTACK* (O_VME_DTACK_EN=1, O_VME_DTACK_D=0) or BERR* (O_VME_BERR=1) and
// holds that answer until the master raises both DS*. A new cycle is only
// accepted after both DS* have been seen high since the previous one.
interface vme_cycle_ctrl_if;
    import vme_pkg::*;

    logic       I_VME_AS;
    logic       I_VME_DS0;
    logic       I_VME_DS1;
    logic       I_VME_WR;
    logic       I_ADDR_HIT;

    logic       O_ADDR_LE;
    logic       O_RD_STB;
    logic       O_WR_STB;
    logic       O_RD_BUF_EN;
    logic       O_WR_BUF_EN;
    logic       O_VME_DTACK_D;
    logic       O_VME_DTACK_EN;
    logic       O_VME_BERR;
    logic       O_ACK_TMO;
    vme_state_e state_dbg;

    modport master (
        output I_VME_AS, I_VME_DS0, I_VME_DS1, I_VME_WR, I_ADDR_HIT,
        input  O_ADDR_LE, O_RD_STB, O_WR_STB, O_RD_BUF_EN, O_WR_BUF_EN,
        input  O_VME_DTACK_D, O_VME_DTACK_EN, O_VME_BERR, O_ACK_TMO,
        input  state_dbg
    );

    modport slave (
        input  I_VME_AS, I_VME_DS0, I_VME_DS1, I_VME_WR, I_ADDR_HIT,
        output O_ADDR_LE, O_RD_STB, O_WR_STB, O_RD_BUF_EN, O_WR_BUF_EN,
        output O_VME_DTACK_D, O_VME_DTACK_EN, O_VME_BERR, O_ACK_TMO,
        output state_dbg
    );

endinterface

// File: rtl/vme_sync.sv
// vme_sync: N-stage flip-flop synchroniser for one asynchronous VME strobe.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; all stages reset to 1 (strobe idle)
//   d     : raw asynchronous input
//   q     : synchronised output, N clocks after d
module vme_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    generate
        if (N == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stages <= '1;
                end else begin
                    stages <= d;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stages <= '1;
                end else begin
                    stages <= {stages[N-2:0], d};
                end
            end
        end
    endgenerate

    assign q = stages[N-1];

endmodule

// File: rtl/vme_cycle_ctrl.sv
// vme_cycle_ctrl: VME slave data-transfer cycle controller.
//   I_CLK_32M        : 32 MHz system clock
//   I_VME_SYSRESET_N : asynchronous active-low reset
//   bus (slave)      : raw VME strobes and decoder hit in; address latch
//                      enable, register read/write strobes, data buffer
//                      enables, DTACK*/BERR* controls, ACK watchdog pulse
//                      and FSM state out.
// Parameters:
//   SYNC_STAGES : synchroniser depth on AS*, DS0*, DS1*, WRITE*
//   DTACK_DLY   : cycles from register strobe to DTACK* low (1..15)
//   ACK_TMO     : cycles DTACK* may stay low waiting for DS release
//   BYTE_OK     : 1 accepts single-DS byte cycles, 0 answers with BERR*
module vme_cycle_ctrl
    import vme_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DTACK_DLY   = DTACK_DLY_DEF,
    parameter int ACK_TMO     = ACK_TMO_DEF,
    parameter bit BYTE_OK     = 1'b0
) (
    input logic             I_CLK_32M,
    input logic             I_VME_SYSRESET_N,
    vme_cycle_ctrl_if.slave bus
);

    logic clk;
    logic rst_n;
    assign clk   = I_CLK_32M;
    assign rst_n = I_VME_SYSRESET_N;

    // ------------------------------------------------------------------
    // Strobe synchronisers
    // ------------------------------------------------------------------
    logic as_s, ds0_s, ds1_s, wr_s;

    vme_sync #(.N(SYNC_STAGES)) u_sync_as  (.clk(clk), .rst_n(rst_n), .d(bus.I_VME_AS),  .q(as_s));
    vme_sync #(.N(SYNC_STAGES)) u_sync_ds0 (.clk(clk), .rst_n(rst_n), .d(bus.I_VME_DS0), .q(ds0_s));
    vme_sync #(.N(SYNC_STAGES)) u_sync_ds1 (.clk(clk), .rst_n(rst_n), .d(bus.I_VME_DS1), .q(ds1_s));
    vme_sync #(.N(SYNC_STAGES)) u_sync_wr  (.clk(clk), .rst_n(rst_n), .d(bus.I_VME_WR),  .q(wr_s));

    // The synchronisers come out of reset reading "high" before any real
    // sample has reached the last stage. Those fake highs must not re-arm
    // the controller, or strobes held low through reset would start a cycle.
    logic [4:0] fill_cnt;
    logic       sync_ok;

    assign sync_ok = (fill_cnt == 5'(SYNC_STAGES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (!sync_ok) begin
            fill_cnt <= fill_cnt + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM and bookkeeping registers
    // ------------------------------------------------------------------
    vme_state_e state, state_next;
    logic       armed;
    logic       dir_rd;
    logic [3:0] dly_cnt;
    logic [7:0] tmo_cnt;

    logic ds_high;
    logic start;
    logic abort;
    logic dly_done;
    logic tmo_hit;

    assign ds_high  = ds_both_high(ds0_s, ds1_s);
    assign start    = armed && !as_s && !ds_high;
    assign abort    = as_s || ds_high;
    assign dly_done = ({1'b0, dly_cnt} + 5'd1) >= 5'(DTACK_DLY);
    assign tmo_hit  = (ACK_TMO != 0) && (({1'b0, tmo_cnt} + 9'd1) == 9'(ACK_TMO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Re-arm only once both DS* are genuinely high; consumed at cycle start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            armed <= 1'b0;
        end else if (sync_ok && ds_high) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_rd <= 1'b0;
        end else if (state == ST_ADDR) begin
            dir_rd <= wr_s;
        end
    end

    // Both counters restart on every state change and saturate instead of
    // wrapping, so a long stay can never alias back to an early count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_cnt <= '0;
            tmo_cnt <= '0;
        end else if (state_next != state) begin
            dly_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == ST_WAIT && dly_cnt != 4'hF) begin
                dly_cnt <= dly_cnt + 4'd1;
            end
            if (state == ST_ACK && tmo_cnt != 8'hFF) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    logic addr_le, rd_stb, wr_stb, rd_buf, wr_buf;
    logic dtack_d, dtack_en, berr, ack_tmo;

    always_comb begin
        state_next = state;
        addr_le    = 1'b0;
        rd_stb     = 1'b0;
        wr_stb     = 1'b0;
        rd_buf     = 1'b0;
        wr_buf     = 1'b0;
        dtack_d    = 1'b1;
        dtack_en   = 1'b0;
        berr       = 1'b0;
        ack_tmo    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                addr_le    = 1'b1;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (!bus.I_ADDR_HIT) begin
                    state_next = ST_SKIP;
                end else if (is_byte_cycle(ds0_s, ds1_s) && !BYTE_OK) begin
                    state_next = ST_ERR;
                end else begin
                    state_next = ST_XFER;
                end
            end
            ST_SKIP: begin
                if (ds_high) begin
                    state_next = ST_IDLE;
                end
            end
            ST_XFER: begin
                rd_stb     = dir_rd;
                wr_stb     = !dir_rd;
                rd_buf     = dir_rd;
                wr_buf     = !dir_rd;
                dtack_en   = 1'b1;
                state_next = abort ? ST_RELEASE : ST_WAIT;
            end
            ST_WAIT: begin
                rd_buf   = dir_rd;
                wr_buf   = !dir_rd;
                dtack_en = 1'b1;
                if (abort) begin
                    state_next = ST_RELEASE;
                end else if (dly_done) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                rd_buf   = dir_rd;
                wr_buf   = !dir_rd;
                dtack_en = 1'b1;
                dtack_d  = 1'b0;
                // A DS release in the same cycle as the timeout wins.
                if (ds_high) begin
                    state_next = ST_RELEASE;
                end else if (tmo_hit) begin
                    ack_tmo    = 1'b1;
                    state_next = ST_RELEASE;
                end
            end
            ST_ERR: begin
                berr = 1'b1;
                if (ds_high) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                // Drive DTACK* actively high for one cycle before tristating.
                dtack_en   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.O_ADDR_LE      = addr_le;
    assign bus.O_RD_STB       = rd_stb;
    assign bus.O_WR_STB       = wr_stb;
    assign bus.O_RD_BUF_EN    = rd_buf;
    assign bus.O_WR_BUF_EN    = wr_buf;
    assign bus.O_VME_DTACK_D  = dtack_d;
    assign bus.O_VME_DTACK_EN = dtack_en;
    assign bus.O_VME_BERR     = berr;
    assign bus.O_ACK_TMO      = ack_tmo;
    assign bus.state_dbg      = state;

endmodule

// File: tb/tb_vme_cycle_ctrl.sv
// tb_vme_cycle_ctrl: self-checking bench for vme_cycle_ctrl.
// Every output edge is turned into an event word {signal, new level, cycle
// offset from the synchronised cycle start} and compared with the expected
// events queued by the stimulus tasks.
module tb_vme_cycle_ctrl;
    import vme_pkg::*;

    // Signal indices inside the event word.
    localparam int S_LE = 0, S_RSTB = 1, S_WSTB = 2, S_RBUF = 3, S_WBUF = 4;
    localparam int S_DTD = 5, S_DTEN = 6, S_BERR = 7, S_TMO = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   t0    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vme_cycle_ctrl_if bus ();

    vme_cycle_ctrl dut (
        .I_CLK_32M        (clk),
        .I_VME_SYSRESET_N (rst_n),
        .bus              (bus)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle offset %0d)", tag, got, exp, cyc - t0);
        end
    endtask

    task automatic exp_ev(input int s, input logic v, input int off);
        exp_q.push_back({4'(s), v, 11'(off)});
    endtask

    // Events from cycle start through the end of the XFER cycle.
    task automatic exp_front(input logic rd);
        exp_ev(S_LE, 1'b1, 1);
        exp_ev(S_LE, 1'b0, 2);
        exp_ev(rd ? S_RSTB : S_WSTB, 1'b1, 3);
        exp_ev(rd ? S_RBUF : S_WBUF, 1'b1, 3);
        exp_ev(S_DTEN, 1'b1, 3);
        exp_ev(rd ? S_RSTB : S_WSTB, 1'b0, 4);
    endtask

    // ---------------- monitor ----------------
    logic [8:0]  prev_o = 9'b0_0010_0000;
    logic [8:0]  cur_o;
    logic [15:0] ev;

    always @(negedge clk) begin
        cur_o = {bus.O_ACK_TMO, bus.O_VME_BERR, bus.O_VME_DTACK_EN, bus.O_VME_DTACK_D,
                 bus.O_WR_BUF_EN, bus.O_RD_BUF_EN, bus.O_WR_STB, bus.O_RD_STB, bus.O_ADDR_LE};
        check("buf_excl", 32'(bus.O_RD_BUF_EN & bus.O_WR_BUF_EN), 32'd0);
        for (int s = 0; s < 9; s++) begin
            if (cur_o[s] !== prev_o[s]) begin
                ev = {4'(s), cur_o[s], 11'(cyc - t0)};
                if (exp_q.size() > 0) begin
                    check("event", 32'(ev), 32'(exp_q.pop_front()));
                end else begin
                    check("unexpected_event", 32'(ev), 32'hDEAD_BEEF);
                end
            end
        end
        prev_o = cur_o;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cycle(input logic wr, input logic ds0, input logic ds1, input logic hit);
        @(negedge clk);
        bus.I_ADDR_HIT = hit;
        bus.I_VME_WR   = wr;
        bus.I_VME_AS   = 1'b0;
        bus.I_VME_DS0  = ds0;
        bus.I_VME_DS1  = ds1;
        t0 = cyc + 2;
    endtask

    // Returns the cycle offset at which the release reaches the sync domain.
    task automatic release_strobes(output int k);
        @(negedge clk);
        bus.I_VME_AS  = 1'b1;
        bus.I_VME_DS0 = 1'b1;
        bus.I_VME_DS1 = 1'b1;
        k = cyc + 2 - t0;
    endtask

    task automatic do_xfer(input logic rd);
        int k;
        start_cycle(rd, 1'b0, 1'b0, 1'b1);
        exp_front(rd);
        exp_ev(S_DTD, 1'b0, 6);
        wait_cyc(8);
        release_strobes(k);
        exp_ev(rd ? S_RBUF : S_WBUF, 1'b0, k + 1);
        exp_ev(S_DTD, 1'b1, k + 1);
        exp_ev(S_DTEN, 1'b0, k + 2);
        wait_cyc(8);
    endtask

    task automatic check_released(input string tag);
        check({tag, "_dtack_d"},  32'(bus.O_VME_DTACK_D),  32'd1);
        check({tag, "_dtack_en"}, 32'(bus.O_VME_DTACK_EN), 32'd0);
        check({tag, "_rd_buf"},   32'(bus.O_RD_BUF_EN),    32'd0);
        check({tag, "_wr_buf"},   32'(bus.O_WR_BUF_EN),    32'd0);
        check({tag, "_berr"},     32'(bus.O_VME_BERR),     32'd0);
        check({tag, "_state"},    32'(bus.state_dbg),      32'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        bus.I_VME_AS   = 1'b1;
        bus.I_VME_DS0  = 1'b1;
        bus.I_VME_DS1  = 1'b1;
        bus.I_VME_WR   = 1'b1;
        bus.I_ADDR_HIT = 1'b0;

        #3;
        check_released("reset");
        check("reset_addr_le", 32'(bus.O_ADDR_LE), 32'd0);
        check("reset_ack_tmo", 32'(bus.O_ACK_TMO), 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(8);

        // Read and write D16 with a decoder hit.
        do_xfer(1'b1);
        do_xfer(1'b0);

        // Decoder miss: only the address latch pulses, bus left alone.
        start_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        exp_ev(S_LE, 1'b1, 1);
        exp_ev(S_LE, 1'b0, 2);
        wait_cyc(8);
        release_strobes(k);
        wait_cyc(8);
        do_xfer(1'b1);

        // Single-DS byte cycle with byte access disabled: BERR until DS high.
        start_cycle(1'b1, 1'b0, 1'b1, 1'b1);
        exp_ev(S_LE, 1'b1, 1);
        exp_ev(S_LE, 1'b0, 2);
        exp_ev(S_BERR, 1'b1, 3);
        wait_cyc(8);
        release_strobes(k);
        exp_ev(S_BERR, 1'b0, k + 1);
        wait_cyc(8);

        // Master abort during XFER: no DTACK low is ever driven.
        start_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        exp_front(1'b1);
        wait_cyc(2);
        release_strobes(k);
        exp_ev(S_RBUF, 1'b0, k + 1);
        exp_ev(S_DTEN, 1'b0, k + 2);
        wait_cyc(8);

        // DS held low past the watchdog.
        start_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        exp_front(1'b1);
        exp_ev(S_DTD, 1'b0, 6);
        exp_ev(S_TMO, 1'b1, 260);
        exp_ev(S_RBUF, 1'b0, 261);
        exp_ev(S_DTD, 1'b1, 261);
        exp_ev(S_TMO, 1'b0, 261);
        exp_ev(S_DTEN, 1'b0, 262);
        wait_cyc(300);
        check("tmo_idle_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        release_strobes(k);
        wait_cyc(8);
        do_xfer(1'b1);

        // Reset during WAIT with strobes still low.
        start_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        exp_front(1'b1);
        exp_ev(S_RBUF, 1'b0, 4);
        exp_ev(S_DTEN, 1'b0, 4);
        repeat (6) @(posedge clk);
        #2;
        check("pre_reset_state", 32'(bus.state_dbg), 32'(ST_WAIT));
        rst_n = 1'b0;
        #1;
        check_released("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(20);
        check("post_reset_no_cycle", 32'(bus.state_dbg), 32'(ST_IDLE));
        release_strobes(k);
        wait_cyc(6);
        do_xfer(1'b0);

        wait_cyc(5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
